regcr_ctx: RTL
==============

// Module: regcr_ctx
// PURPOSE
// - Parametrised capability register file, successor to the fixed CR0..CR3 file.
// - Holds NUM_CR capabilities as uncompressed fields: base, len, cur, perms, attr, tag.
// - Adds N read ports with write bypass, a tag-clearing write rule, and a cursor-increment port with bounds flag.
// - Adds a save/restore engine that streams the whole file out and in over valid/ready channels for context switches.
// PARAMETERS
// - NUM_CR  4   number of capability registers (>=2, power of two); CRW = clog2(NUM_CR)
// - NUM_RD  2   number of combinational read ports
// - ADDR_W  48  base/len/cur width (BAU)
// - DATA_W  24  perms/attr width
// - BYPASS  1   1: a read of a register written this cycle returns the new field value
// - RECW = 3*ADDR_W+2*DATA_W+1; record = {tag,attr,perms,cur,len,base}
// PORTS
// - iw_clk         in   1             clock
// - iw_rst         in   1             asynchronous, active-high reset
// - iw_rd_addr     in   NUM_RD*CRW    read addresses, port k at [k*CRW+:CRW]
// - ow_rd_rec      out  NUM_RD*RECW   read records, port k at [k*RECW+:RECW]
// - iw_wr_addr     in   CRW           write address
// - iw_wr_en       in   6             field enables {tag,attr,perms,cur,len,base}
// - iw_wr_rec      in   RECW          write data, record layout
// - iw_inc_en      in   1             cursor increment request
// - iw_inc_addr    in   CRW           increment target
// - iw_inc_delta   in   ADDR_W        signed two's-complement delta
// - ow_inc_oob     out  1             registered: new cur outside [base, base+len)
// - ow_inc_drop    out  1             registered: increment discarded
// - ow_wr_reject   out  1             registered: write/inc ignored while busy
// - iw_sv_start    in   1             start engine; ignored unless idle
// - iw_sv_dir      in   1             0 = save, 1 = restore; sampled with start
// - ow_sv_valid    out  1             save stream valid
// - ow_sv_rec      out  RECW          save stream data
// - iw_sv_ready    in   1             save stream ready
// - iw_rs_valid    in   1             restore stream valid
// - iw_rs_rec      in   RECW          restore stream data
// - ow_rs_ready    out  1             restore stream ready
// - ow_busy        out  1             engine not idle
// - ow_done        out  1             one-cycle pulse when engine completes
// BEHAVIOUR
// - Reset clears every field of every CR and returns the FSM to IDLE.
// - Reset values of all outputs are 0; ow_rd_rec then reads 0.
// - Reset mid-transfer aborts it; no partial-state recovery.
// - Reads are combinational. With BYPASS=1, each enabled field of a same-cycle write to the same address is forwarded.
// - Writes and increments commit on the clock edge.
// - Tag rule: a write enabling base/len/perms/attr without enabling tag clears the tag. A cur-only write keeps it.
// - Increment: cur <= cur + delta, modulo 2^ADDR_W.
//   - ow_inc_oob = (new_cur < base) || (new_cur - base >= len), compared unsigned, evaluated in ADDR_W+1 bits.
//   - len == 0 always sets oob. The flag is registered: valid the cycle after the request, held 1 cycle.
// - Write/increment collision: write wins when both target the same address and the write enables cur.
//   - The increment is then discarded; ow_inc_drop pulses the next cycle.
//   - A write to another field of the same address does not block the increment.
// - FSM states: IDLE -> SAVE | RESTORE on iw_sv_start, with index idx = 0.
//   - SAVE: ow_sv_valid=1, ow_sv_rec = CR[idx]. On valid&&ready, idx++. Ready after the last CR -> DONE.
//   - RESTORE: ow_rs_ready=1. On valid&&ready, CR[idx] <= iw_rs_rec with all fields and tag as given; idx++. After the last CR -> DONE.
//   - DONE: ow_done=1 for one cycle -> IDLE.
//   - ow_busy=1 in SAVE, RESTORE and DONE.
// - While busy, architectural writes and increments are ignored and ow_wr_reject pulses the next cycle.
//   - Reads remain live. During RESTORE they return the register contents at that moment.
// - Save data is held stable while valid && !ready. Back-pressure may stall indefinitely.
// STRUCTURE
// - Shared package header cr.vh: RECW, field offsets, the iw_wr_en bit order, and FSM state encodings.
// - One sub-module, regcr_bounds: combinational oob check (cur, base, len -> oob), reused later by the LSU.
// TESTING
// - Reset, then write CR1 base=0x100 len=0x40 tag=1; read CR1 on both ports the same cycle -> bypass shows 0x100/0x40/tag=1.
// - CR1 tagged, then write perms only -> tag reads 0 next cycle. Cur-only write on a tagged CR -> tag stays 1.
// - CR2 base=0x100 len=0x40 cur=0x13F: inc +1 -> cur=0x140, oob=1; inc -0x40 -> cur=0x100, oob=0; len=0 -> oob=1.
// - Same-cycle cur write 0x200 and inc +8 to CR3 -> cur=0x200, inc_drop=1. Inc on CR3 with base write on CR0 -> both apply.
// - Save with ready toggling every other cycle -> 4 records in CR order, data stable while stalled, done after the last.
// - Restore 4 records -> file matches them. A write while busy -> wr_reject=1, no change. Reset after record 2 -> all zero, IDLE.

Source files
------------

// File: rtl/regcr_ctx_pkg.sv
// Shared definitions for the capability register file.
//  - record layout helpers: {tag, attr, perms, cur, len, base}, base in the LSBs
//  - bit positions of the per-field write-enable vector
//  - save/restore engine state encodings
package regcr_ctx_pkg;

   // Bit positions inside the 6-bit field-enable vector.
   localparam int WE_BASE  = 0;
   localparam int WE_LEN   = 1;
   localparam int WE_CUR   = 2;
   localparam int WE_PERMS = 3;
   localparam int WE_ATTR  = 4;
   localparam int WE_TAG   = 5;

   // Save/restore engine states.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SAVE    = 2'd1;
   localparam logic [1:0] ST_RESTORE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   function automatic int rec_w(input int aw, input int dw);
      return 3*aw + 2*dw + 1;
   endfunction

   function automatic int off_len(input int aw);
      return aw;
   endfunction

   function automatic int off_cur(input int aw);
      return 2*aw;
   endfunction

   function automatic int off_perms(input int aw);
      return 3*aw;
   endfunction

   function automatic int off_attr(input int aw, input int dw);
      return 3*aw + dw;
   endfunction

   function automatic int off_tag(input int aw, input int dw);
      return 3*aw + 2*dw;
   endfunction

endpackage

// File: rtl/regcr_ctx_bounds.sv
// regcr_bounds: combinational capability bounds check.
//  cur, base, len : ADDR_W-bit unsigned addresses/length
//  oob            : 1 when cur lies outside [base, base+len)
// The subtraction is done one bit wider so a borrow (cur < base) is seen
// directly; len == 0 always reports out of bounds since diff >= 0.
module regcr_bounds
   import regcr_ctx_pkg::*;
#(
   parameter int ADDR_W = 48
)(
   input  logic [ADDR_W-1:0] cur,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] len,
   output logic              oob
);

   logic [ADDR_W:0] diff;

   assign diff = {1'b0, cur} - {1'b0, base};
   assign oob  = diff[ADDR_W] || (diff[ADDR_W-1:0] >= len);

endmodule

// File: rtl/regcr_ctx.sv
// regcr_ctx: parametrised capability register file with save/restore engine.
//  iw_clk / iw_rst         clock, asynchronous active-high reset
//  iw_rd_addr / ow_rd_rec  NUM_RD combinational read ports (optional write bypass)
//  iw_wr_*                 per-field write; tag is cleared when base/len/perms/attr
//                          are written without the tag
//  iw_inc_* / ow_inc_*     cursor increment, registered out-of-bounds and drop flags
//  ow_wr_reject            registered: write/increment arrived while the engine was busy
//  iw_sv_* / ow_sv_*       engine start/direction and save stream (valid/ready)
//  iw_rs_* / ow_rs_ready   restore stream (valid/ready)
//  ow_busy / ow_done       engine not idle / one-cycle completion pulse
module regcr_ctx
   import regcr_ctx_pkg::*;
#(
   parameter int NUM_CR = 4,
   parameter int NUM_RD = 2,
   parameter int ADDR_W = 48,
   parameter int DATA_W = 24,
   parameter int BYPASS = 1
)(
   input  logic                                            iw_clk,
   input  logic                                            iw_rst,
   input  logic [NUM_RD*$clog2(NUM_CR)-1:0]                iw_rd_addr,
   output logic [NUM_RD*(3*ADDR_W+2*DATA_W+1)-1:0]         ow_rd_rec,
   input  logic [$clog2(NUM_CR)-1:0]                       iw_wr_addr,
   input  logic [5:0]                                      iw_wr_en,
   input  logic [3*ADDR_W+2*DATA_W:0]                      iw_wr_rec,
   input  logic                                            iw_inc_en,
   input  logic [$clog2(NUM_CR)-1:0]                       iw_inc_addr,
   input  logic [ADDR_W-1:0]                               iw_inc_delta,
   output logic                                            ow_inc_oob,
   output logic                                            ow_inc_drop,
   output logic                                            ow_wr_reject,
   input  logic                                            iw_sv_start,
   input  logic                                            iw_sv_dir,
   output logic                                            ow_sv_valid,
   output logic [3*ADDR_W+2*DATA_W:0]                      ow_sv_rec,
   input  logic                                            iw_sv_ready,
   input  logic                                            iw_rs_valid,
   input  logic [3*ADDR_W+2*DATA_W:0]                      iw_rs_rec,
   output logic                                            ow_rs_ready,
   output logic                                            ow_busy,
   output logic                                            ow_done
);

   localparam int CRW     = $clog2(NUM_CR);
   localparam int RECW    = rec_w(ADDR_W, DATA_W);
   localparam int O_LEN   = off_len(ADDR_W);
   localparam int O_CUR   = off_cur(ADDR_W);
   localparam int O_PERMS = off_perms(ADDR_W);
   localparam int O_ATTR  = off_attr(ADDR_W, DATA_W);
   localparam int O_TAG   = off_tag(ADDR_W, DATA_W);
   localparam logic [CRW-1:0] LAST_IDX = CRW'(NUM_CR - 1);

   logic [ADDR_W-1:0] base_q  [NUM_CR];
   logic [ADDR_W-1:0] len_q   [NUM_CR];
   logic [ADDR_W-1:0] cur_q   [NUM_CR];
   logic [DATA_W-1:0] perms_q [NUM_CR];
   logic [DATA_W-1:0] attr_q  [NUM_CR];
   logic              tag_q   [NUM_CR];

   logic [1:0]     state_q;
   logic [CRW-1:0] idx_q;

   logic idle, wr_req, wr_act, inc_act, inc_drop, inc_do, tag_clr;
   logic sv_acc, rs_acc, inc_oob;
   logic [ADDR_W-1:0] inc_cur;

   logic [ADDR_W-1:0] wr_base, wr_len, wr_cur;
   logic [DATA_W-1:0] wr_perms, wr_attr;
   logic              wr_tag;

   assign wr_base  = iw_wr_rec[0 +: ADDR_W];
   assign wr_len   = iw_wr_rec[O_LEN +: ADDR_W];
   assign wr_cur   = iw_wr_rec[O_CUR +: ADDR_W];
   assign wr_perms = iw_wr_rec[O_PERMS +: DATA_W];
   assign wr_attr  = iw_wr_rec[O_ATTR +: DATA_W];
   assign wr_tag   = iw_wr_rec[O_TAG];

   assign idle    = (state_q == ST_IDLE);
   assign wr_req  = |iw_wr_en;
   assign wr_act  = wr_req && idle;
   assign inc_act = iw_inc_en && idle;
   assign tag_clr = iw_wr_en[WE_BASE] | iw_wr_en[WE_LEN] | iw_wr_en[WE_PERMS] | iw_wr_en[WE_ATTR];

   // A cur write to the same register overrides the increment entirely.
   assign inc_drop = inc_act && wr_act && iw_wr_en[WE_CUR] && (iw_wr_addr == iw_inc_addr);
   assign inc_do   = inc_act && !inc_drop;

   // Two's-complement add is identical for signed and unsigned deltas; wraps mod 2^ADDR_W.
   assign inc_cur = cur_q[iw_inc_addr] + iw_inc_delta;

   // Bounds use the register's pre-edge base/len, even if a same-cycle
   // write to another field of that register is committing alongside.
   regcr_bounds #(.ADDR_W(ADDR_W)) u_bounds (
      .cur  (inc_cur),
      .base (base_q[iw_inc_addr]),
      .len  (len_q[iw_inc_addr]),
      .oob  (inc_oob)
   );

   assign sv_acc = (state_q == ST_SAVE) && iw_sv_ready;
   assign rs_acc = (state_q == ST_RESTORE) && iw_rs_valid;

   // Register file: restore, increment and architectural write commit here.
   // Restore only happens when not idle, so it never overlaps the other two.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         for (int i = 0; i < NUM_CR; i++) begin
            base_q[i]  <= '0;
            len_q[i]   <= '0;
            cur_q[i]   <= '0;
            perms_q[i] <= '0;
            attr_q[i]  <= '0;
            tag_q[i]   <= 1'b0;
         end
      end else begin
         if (rs_acc) begin
            base_q[idx_q]  <= iw_rs_rec[0 +: ADDR_W];
            len_q[idx_q]   <= iw_rs_rec[O_LEN +: ADDR_W];
            cur_q[idx_q]   <= iw_rs_rec[O_CUR +: ADDR_W];
            perms_q[idx_q] <= iw_rs_rec[O_PERMS +: DATA_W];
            attr_q[idx_q]  <= iw_rs_rec[O_ATTR +: DATA_W];
            tag_q[idx_q]   <= iw_rs_rec[O_TAG];
         end
         if (inc_do)
            cur_q[iw_inc_addr] <= inc_cur;
         if (wr_act) begin
            if (iw_wr_en[WE_BASE])  base_q[iw_wr_addr]  <= wr_base;
            if (iw_wr_en[WE_LEN])   len_q[iw_wr_addr]   <= wr_len;
            if (iw_wr_en[WE_CUR])   cur_q[iw_wr_addr]   <= wr_cur;
            if (iw_wr_en[WE_PERMS]) perms_q[iw_wr_addr] <= wr_perms;
            if (iw_wr_en[WE_ATTR])  attr_q[iw_wr_addr]  <= wr_attr;
            if (iw_wr_en[WE_TAG])
               tag_q[iw_wr_addr] <= wr_tag;
            else if (tag_clr)
               tag_q[iw_wr_addr] <= 1'b0;
         end
      end
   end

   // Save/restore engine.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (iw_sv_start) begin
                  state_q <= iw_sv_dir ? ST_RESTORE : ST_SAVE;
                  idx_q   <= '0;
               end
            end
            ST_SAVE, ST_RESTORE: begin
               if (sv_acc || rs_acc) begin
                  if (idx_q == LAST_IDX)
                     state_q <= ST_DONE;
                  else
                     idx_q <= idx_q + CRW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Registered status flags, each a single-cycle pulse.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         ow_inc_oob   <= 1'b0;
         ow_inc_drop  <= 1'b0;
         ow_wr_reject <= 1'b0;
      end else begin
         ow_inc_oob   <= inc_do && inc_oob;
         ow_inc_drop  <= inc_drop;
         ow_wr_reject <= !idle && (wr_req || iw_inc_en);
      end
   end

   assign ow_busy     = !idle;
   assign ow_done     = (state_q == ST_DONE);
   assign ow_sv_valid = (state_q == ST_SAVE);
   assign ow_rs_ready = (state_q == ST_RESTORE);
   assign ow_sv_rec   = ow_sv_valid ?
      {tag_q[idx_q], attr_q[idx_q], perms_q[idx_q], cur_q[idx_q], len_q[idx_q], base_q[idx_q]} :
      '0;

   // Read ports; with bypass, only the fields enabled by a committing write are forwarded.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [CRW-1:0] a;
      logic           hit;
      logic [ADDR_W-1:0] b, l, c;
      logic [DATA_W-1:0] p, at;
      logic              t;

      assign a   = iw_rd_addr[k*CRW +: CRW];
      assign hit = (BYPASS != 0) && wr_act && (iw_wr_addr == a);
      assign b   = (hit && iw_wr_en[WE_BASE])  ? wr_base  : base_q[a];
      assign l   = (hit && iw_wr_en[WE_LEN])   ? wr_len   : len_q[a];
      assign c   = (hit && iw_wr_en[WE_CUR])   ? wr_cur   : cur_q[a];
      assign p   = (hit && iw_wr_en[WE_PERMS]) ? wr_perms : perms_q[a];
      assign at  = (hit && iw_wr_en[WE_ATTR])  ? wr_attr  : attr_q[a];
      assign t   = (hit && iw_wr_en[WE_TAG])   ? wr_tag   : tag_q[a];
      assign ow_rd_rec[k*RECW +: RECW] = {t, at, p, c, l, b};
   end

endmodule
